// File: rtl/tts_monitor.sv
// tts_monitor: receive side of the 4-bit TTS status link.
// Registers the raw code, debounces it with a stability filter, decodes the
// accepted code into a state class and keeps entry counters, sticky flags and
// a dwell timer for slow-control readout. All outputs are registered.
module tts_monitor #(
    parameter int STABLE_CYCLES = 4,   // 1..255
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 reset,          // async, active-low
    input  logic [3:0]           tts_in,
    input  logic                 clear_counts,
    output logic [3:0]           tts_state,
    output logic [2:0]           tts_decoded,
    output logic                 state_change,
    output logic                 not_ready,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] sync_count,
    output logic [CNT_WIDTH-1:0] ovf_count,
    output logic [CNT_WIDTH-1:0] invalid_count,
    output logic [31:0]          dwell_count,
    output logic [5:0]           sticky
);

    localparam logic [2:0] CLS_READY   = 3'd0;
    localparam logic [2:0] CLS_OVF     = 3'd1;
    localparam logic [2:0] CLS_SYNC    = 3'd2;
    localparam logic [2:0] CLS_ERROR   = 3'd3;
    localparam logic [2:0] CLS_DISCONN = 3'd4;
    localparam logic [2:0] CLS_INVALID = 3'd5;

    localparam logic [7:0]           STABLE_L = 8'(STABLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    // Map a raw 4-bit TTS code onto its state class.
    function automatic logic [2:0] decode_tts(input logic [3:0] code);
        logic [2:0] cls;
        case (code)
            4'b1000: cls = CLS_READY;
            4'b0001: cls = CLS_OVF;
            4'b0010: cls = CLS_SYNC;
            4'b1100: cls = CLS_ERROR;
            4'b0000: cls = CLS_DISCONN;
            4'b1111: cls = CLS_DISCONN;
            default: cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

    // Next value of an entry counter: an entry beats a same-edge clear,
    // and the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] next_count(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 hit,
        input logic                 clr
    );
        logic [CNT_WIDTH-1:0] nxt;
        if (hit) begin
            if (clr) begin
                nxt = CNT_ONE;
            end else if (&cur) begin
                nxt = cur;
            end else begin
                nxt = cur + CNT_ONE;
            end
        end else if (clr) begin
            nxt = '0;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    logic [3:0]           r_tts_q;
    logic [3:0]           r_cand;
    logic [7:0]           r_cnt;
    logic [3:0]           r_tts_state;
    logic [2:0]           r_decoded;
    logic                 r_state_change;
    logic                 r_not_ready;
    logic [CNT_WIDTH-1:0] r_err;
    logic [CNT_WIDTH-1:0] r_sync;
    logic [CNT_WIDTH-1:0] r_ovf;
    logic [CNT_WIDTH-1:0] r_inv;
    logic [31:0]          r_dwell;
    logic [5:0]           r_sticky;

    logic [3:0]           w_next_cand;
    logic [7:0]           w_next_cnt;
    logic                 w_becomes;
    logic                 w_accept;
    logic [2:0]           w_new_cls;
    logic [5:0]           w_entry_mask;

    // Stability filter next state and acceptance decision.
    always_comb begin
        w_next_cand = r_cand;
        w_next_cnt  = r_cnt;
        w_becomes   = 1'b0;
        if (r_tts_q != r_cand) begin
            w_next_cand = r_tts_q;
            w_next_cnt  = 8'd1;
            w_becomes   = (STABLE_L == 8'd1);
        end else if (r_cnt != STABLE_L) begin
            w_next_cnt  = r_cnt + 8'd1;
            w_becomes   = ((r_cnt + 8'd1) == STABLE_L);
        end else begin
            w_next_cnt  = r_cnt;
        end
        w_accept  = w_becomes && (w_next_cand != r_tts_state);
        w_new_cls = decode_tts(w_next_cand);
        if (w_accept) begin
            w_entry_mask = 6'b000001 << w_new_cls;
        end else begin
            w_entry_mask = 6'b000000;
        end
    end

    // Input sample register and filter candidate/stability counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tts_q <= 4'b0000;
            r_cand  <= 4'b0000;
            r_cnt   <= 8'd0;
        end else begin
            r_tts_q <= tts_in;
            r_cand  <= w_next_cand;
            r_cnt   <= w_next_cnt;
        end
    end

    // Accepted code, its decoded class, the change pulse and dwell timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tts_state    <= 4'b0000;
            r_decoded      <= CLS_DISCONN;
            r_not_ready    <= 1'b1;
            r_state_change <= 1'b0;
            r_dwell        <= 32'd0;
        end else if (w_accept) begin
            r_tts_state    <= w_next_cand;
            r_decoded      <= w_new_cls;
            r_not_ready    <= (w_new_cls != CLS_READY);
            r_state_change <= 1'b1;
            r_dwell        <= 32'd0;
        end else begin
            r_state_change <= 1'b0;
            if (r_dwell != 32'hFFFF_FFFF) begin
                r_dwell <= r_dwell + 32'd1;
            end else begin
                r_dwell <= r_dwell;
            end
        end
    end

    // Entry counters and sticky flags; an entry overrides a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err    <= '0;
            r_sync   <= '0;
            r_ovf    <= '0;
            r_inv    <= '0;
            r_sticky <= 6'b000000;
        end else begin
            r_err    <= next_count(r_err,  w_entry_mask[CLS_ERROR],   clear_counts);
            r_sync   <= next_count(r_sync, w_entry_mask[CLS_SYNC],    clear_counts);
            r_ovf    <= next_count(r_ovf,  w_entry_mask[CLS_OVF],     clear_counts);
            r_inv    <= next_count(r_inv,  w_entry_mask[CLS_INVALID], clear_counts);
            if (clear_counts) begin
                r_sticky <= w_entry_mask;
            end else begin
                r_sticky <= r_sticky | w_entry_mask;
            end
        end
    end

    assign tts_state     = r_tts_state;
    assign tts_decoded   = r_decoded;
    assign state_change  = r_state_change;
    assign not_ready     = r_not_ready;
    assign err_count     = r_err;
    assign sync_count    = r_sync;
    assign ovf_count     = r_ovf;
    assign invalid_count = r_inv;
    assign dwell_count   = r_dwell;
    assign sticky        = r_sticky;

endmodule

// File: tb/tb_tts_monitor.sv
// Self-checking bench for tts_monitor. Stimulus pushes the expected snapshot
// of each acceptance into a scoreboard; a monitor pops and compares on every
// state_change pulse, including the clock edge at which it appears.
module tb_tts_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_counts;
    logic [3:0]  tts_in;
    logic [3:0]  tts_in2;

    logic [3:0]  tts_state;
    logic [2:0]  tts_decoded;
    logic        state_change;
    logic        not_ready;
    logic [15:0] err_count, sync_count, ovf_count, invalid_count;
    logic [31:0] dwell_count;
    logic [5:0]  sticky;

    logic [3:0]  tts_state2;
    logic [2:0]  tts_decoded2;
    logic        state_change2;
    logic        not_ready2;
    logic [1:0]  err_count2, sync_count2, ovf_count2, invalid_count2;
    logic [31:0] dwell_count2;
    logic [5:0]  sticky2;

    tts_monitor #(.STABLE_CYCLES(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset), .tts_in(tts_in), .clear_counts(clear_counts),
        .tts_state(tts_state), .tts_decoded(tts_decoded), .state_change(state_change),
        .not_ready(not_ready), .err_count(err_count), .sync_count(sync_count),
        .ovf_count(ovf_count), .invalid_count(invalid_count),
        .dwell_count(dwell_count), .sticky(sticky)
    );

    tts_monitor #(.STABLE_CYCLES(4), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .tts_in(tts_in2), .clear_counts(1'b0),
        .tts_state(tts_state2), .tts_decoded(tts_decoded2), .state_change(state_change2),
        .not_ready(not_ready2), .err_count(err_count2), .sync_count(sync_count2),
        .ovf_count(ovf_count2), .invalid_count(invalid_count2),
        .dwell_count(dwell_count2), .sticky(sticky2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        int          acc_cyc;
        logic [3:0]  st;
        logic [2:0]  dec;
        logic        nr;
        logic [15:0] err;
        logic [15:0] sync;
        logic [15:0] ovf;
        logic [15:0] inv;
        logic [5:0]  stk;
    } exp_t;

    exp_t sb[$];

    // Reference state of the accepted code and readout registers.
    logic [3:0]  m_state;
    logic [15:0] m_err, m_sync, m_ovf, m_inv;
    logic [5:0]  m_sticky;
    int          last_acc;

    function automatic logic [2:0] tdec(input logic [3:0] c);
        case (c)
            4'b1000: return 3'd0;
            4'b0001: return 3'd1;
            4'b0010: return 3'd2;
            4'b1100: return 3'd3;
            4'b0000: return 3'd4;
            4'b1111: return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_state  = 4'b0000;
        m_err    = 16'd0;
        m_sync   = 16'd0;
        m_ovf    = 16'd0;
        m_inv    = 16'd0;
        m_sticky = 6'b000000;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  {60'd0, tts_state},   64'h0);
        chk({tag, "_dec"},    {61'd0, tts_decoded}, 64'd4);
        chk({tag, "_nr"},     {63'd0, not_ready},   64'd1);
        chk({tag, "_sc"},     {63'd0, state_change}, 64'd0);
        chk({tag, "_cnts"},   {err_count, sync_count, ovf_count, invalid_count}, 64'd0);
        chk({tag, "_dwell_sticky"}, {26'd0, sticky, dwell_count}, 64'd0);
    endtask

    // Hold code on tts_in for n sampled edges (called at a falling edge).
    // If it is accepted, its snapshot is queued for the accept edge cyc+5.
    task automatic drive_code(input logic [3:0] code, input int n, input bit clr);
        int         c;
        logic [2:0] cls;
        exp_t       e;
        c      = cyc;
        tts_in = code;
        if (n >= 4 && code != m_state) begin
            cls     = tdec(code);
            m_state = code;
            if (clr) begin
                m_err = 16'd0; m_sync = 16'd0; m_ovf = 16'd0; m_inv = 16'd0;
                m_sticky = 6'b000000;
            end
            case (cls)
                3'd1:    m_ovf  = m_ovf + 16'd1;
                3'd2:    m_sync = m_sync + 16'd1;
                3'd3:    m_err  = m_err + 16'd1;
                3'd5:    m_inv  = m_inv + 16'd1;
                default: ;
            endcase
            m_sticky  = m_sticky | (6'b000001 << cls);
            e.acc_cyc = c + 5;
            e.st      = code;
            e.dec     = cls;
            e.nr      = (cls != 3'd0);
            e.err     = m_err;
            e.sync    = m_sync;
            e.ovf     = m_ovf;
            e.inv     = m_inv;
            e.stk     = m_sticky;
            sb.push_back(e);
            last_acc  = c + 5;
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            clear_counts = (clr && cyc == c + 4);
        end
        clear_counts = 1'b0;
    endtask

    // Scoreboard monitor: every state_change pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && state_change === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: got pulse at edge %0d state %b expected no pulse",
                         cyc, tts_state);
            end else begin
                e = sb.pop_front();
                if (cyc != e.acc_cyc || tts_state !== e.st || tts_decoded !== e.dec ||
                    not_ready !== e.nr || err_count !== e.err || sync_count !== e.sync ||
                    ovf_count !== e.ovf || invalid_count !== e.inv || sticky !== e.stk ||
                    dwell_count !== 32'd0) begin
                    n_fail++;
                    $display("FAIL pulse_snapshot: got edge=%0d st=%b dec=%0d nr=%0d err=%0d sync=%0d ovf=%0d inv=%0d stk=%b dwell=%0d expected edge=%0d st=%b dec=%0d nr=%0d err=%0d sync=%0d ovf=%0d inv=%0d stk=%b dwell=0",
                             cyc, tts_state, tts_decoded, not_ready, err_count, sync_count,
                             ovf_count, invalid_count, sticky, dwell_count,
                             e.acc_cyc, e.st, e.dec, e.nr, e.err, e.sync, e.ovf, e.inv, e.stk);
                end
            end
        end
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b0;
        clear_counts = 1'b0;
        tts_in       = 4'b1000;
        tts_in2      = 4'b1000;
        last_acc     = 0;
        model_reset();

        // 1) reset values, then release with READY held
        repeat (3) @(negedge clk);
        chk_reset_vals("t1_reset");
        reset = 1'b1;
        drive_code(4'b1000, 8, 1'b0);
        chk("t1_sticky", {58'd0, sticky}, 64'b000001);
        chk("t1_nr", {63'd0, not_ready}, 64'd0);

        // 2) short ERROR glitch is ignored, long ERROR is counted
        drive_code(4'b1100, 3, 1'b0);
        drive_code(4'b1000, 6, 1'b0);
        chk("t2_glitch_err", {48'd0, err_count}, 64'd0);
        drive_code(4'b1100, 20, 1'b0);
        chk("t2_dwell15", {32'd0, dwell_count}, 64'(cyc - last_acc));
        @(negedge clk);
        chk("t2_dwell16", {32'd0, dwell_count}, 64'd16);
        chk("t2_err", {48'd0, err_count}, 64'd1);
        chk("t2_sticky3", {63'd0, sticky[3]}, 64'd1);

        // 3) INVALID, then two DISCONN codes (same class, both accepted)
        drive_code(4'b0101, 8, 1'b0);
        chk("t3_dec_inv", {61'd0, tts_decoded}, 64'd5);
        chk("t3_inv", {48'd0, invalid_count}, 64'd1);
        drive_code(4'b0000, 8, 1'b0);
        drive_code(4'b1111, 8, 1'b0);
        chk("t3_dec_disc", {61'd0, tts_decoded}, 64'd4);
        chk("t3_cnts", {err_count, sync_count, ovf_count, invalid_count}, {16'd1, 16'd0, 16'd0, 16'd1});

        // 4) 2-bit counters saturate: five SYNC_LOST entries -> 3
        for (int k = 0; k < 5; k++) begin
            tts_in2 = 4'b0010;
            repeat (6) @(negedge clk);
            tts_in2 = 4'b1000;
            repeat (6) @(negedge clk);
        end
        chk("t4_sync_sat", {62'd0, sync_count2}, 64'd3);
        chk("t4_sticky2", {58'd0, sticky2}, 64'b000101);
        chk("t4_dec2", {61'd0, tts_decoded2}, 64'd0);

        // 5) clear on the accept edge of an OVF entry with ovf_count=7
        for (int k = 0; k < 7; k++) begin
            drive_code(4'b0001, 6, 1'b0);
            drive_code(4'b1000, 6, 1'b0);
        end
        chk("t5_ovf7", {48'd0, ovf_count}, 64'd7);
        drive_code(4'b0001, 6, 1'b1);
        chk("t5_ovf1", {48'd0, ovf_count}, 64'd1);
        chk("t5_others", {err_count, sync_count, invalid_count}, 64'd0);
        chk("t5_sticky", {58'd0, sticky}, 64'b000010);

        // 6) reset at cnt=3 of a pending ERROR discards the progress
        tts_in = 4'b1100;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_reset");
        @(negedge clk);
        chk("t6_reset_sc", {63'd0, state_change}, 64'd0);
        reset = 1'b1;
        model_reset();
        drive_code(4'b1100, 8, 1'b0);
        chk("t6_err", {48'd0, err_count}, 64'd1);
        chk("t6_sticky", {58'd0, sticky}, 64'b001000);

        repeat (10) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
